// File: rtl/mask_centroid_tracker.sv
// Per-frame object tracker for the binary mask stream: accumulates white-pixel
// count, coordinate sums and bounding box, then divides out the centroid at vsync.
module mask_centroid_tracker #(
  parameter  int unsigned LINE_WIDTH  = 640,
  parameter  int unsigned LINE_HEIGHT = 480,
  parameter  int unsigned PIXEL_DEPTH = 8,
  parameter  int unsigned MIN_PIXELS  = 64,
  localparam int unsigned X_W   = $clog2(LINE_WIDTH),
  localparam int unsigned Y_W   = $clog2(LINE_HEIGHT),
  localparam int unsigned CNT_W = $clog2(LINE_WIDTH * LINE_HEIGHT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   vs_ni,
  input  logic                   hs_ni,
  input  logic                   blank_ni,
  input  logic [PIXEL_DEPTH-1:0] input_R,
  input  logic [PIXEL_DEPTH-1:0] input_G,
  input  logic [PIXEL_DEPTH-1:0] input_B,
  output logic                   frame_valid_o,
  output logic                   obj_found_o,
  output logic [CNT_W-1:0]       pixel_count_o,
  output logic [X_W-1:0]         centroid_x_o,
  output logic [Y_W-1:0]         centroid_y_o,
  output logic [X_W-1:0]         min_x_o,
  output logic [X_W-1:0]         max_x_o,
  output logic [Y_W-1:0]         min_y_o,
  output logic [Y_W-1:0]         max_y_o,
  output logic                   overrun_o
);

  localparam int unsigned XY_W  = (X_W > Y_W) ? X_W : Y_W;
  localparam int unsigned DIV_W = CNT_W + XY_W;
  localparam int unsigned SX_W  = CNT_W + X_W;
  localparam int unsigned SY_W  = CNT_W + Y_W;
  localparam int unsigned DC_W  = $clog2(DIV_W + 1);

  localparam logic [X_W:0]       X_LIM    = (X_W + 1)'(LINE_WIDTH);
  localparam logic [Y_W:0]       Y_LIM    = (Y_W + 1)'(LINE_HEIGHT);
  localparam logic [X_W:0]       X_ONE    = (X_W + 1)'(1);
  localparam logic [Y_W:0]       Y_ONE    = (Y_W + 1)'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   MIN_CNT  = CNT_W'(MIN_PIXELS);
  localparam logic [DC_W-1:0]    DC_ONE   = DC_W'(1);
  localparam logic [DC_W-1:0]    DC_LAST  = DC_W'(DIV_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

  state_t state_q, state_d;

  logic             vs_q, blank_q;
  logic [X_W:0]     x_cnt;
  logic [Y_W:0]     y_cnt;
  logic [CNT_W-1:0] acc_cnt;
  logic [SX_W-1:0]  acc_sx;
  logic [SY_W-1:0]  acc_sy;
  logic [X_W-1:0]   acc_min_x, acc_max_x;
  logic [Y_W-1:0]   acc_min_y, acc_max_y;

  logic [CNT_W-1:0] sh_cnt;
  logic [X_W-1:0]   sh_min_x, sh_max_x;
  logic [Y_W-1:0]   sh_min_y, sh_max_y;
  logic             sh_ok;

  logic [DIV_W-1:0] div_x, div_y;
  logic [CNT_W-1:0] rem_x, rem_y;
  logic [DC_W-1:0]  div_step;

  logic frame_end_c, line_end_c, white_c, obj_c, enough_c, take_c;
  logic [X_W-1:0] px_x_c;
  logic [Y_W-1:0] px_y_c;
  logic [CNT_W:0] den_c, rem_x_sh, rem_y_sh;
  logic           q_x, q_y;
  logic [CNT_W-1:0] rem_x_nx, rem_y_nx;

  // hsync carries nothing the blank edges do not already provide
  logic hs_unused;
  assign hs_unused = hs_ni;

  assign frame_end_c = en_i & vs_q & ~vs_ni;
  assign line_end_c  = en_i & blank_q & ~blank_ni;
  assign white_c     = (&input_R) & (&input_G) & (&input_B);
  assign obj_c       = en_i & blank_ni & ~frame_end_c & white_c &
                       (x_cnt < X_LIM) & (y_cnt < Y_LIM);
  assign enough_c    = (acc_cnt >= MIN_CNT) && (acc_cnt != '0);
  assign take_c      = frame_end_c && (state_q == S_IDLE);
  assign px_x_c      = X_W'(x_cnt);
  assign px_y_c      = Y_W'(y_cnt);

  // One restoring-division step for both coordinates against the shadow count
  always_comb begin
    den_c    = {1'b0, sh_cnt};
    rem_x_sh = {rem_x, div_x[DIV_W-1]};
    rem_y_sh = {rem_y, div_y[DIV_W-1]};
    q_x      = (rem_x_sh >= den_c);
    q_y      = (rem_y_sh >= den_c);
    rem_x_nx = CNT_W'(q_x ? (rem_x_sh - den_c) : rem_x_sh);
    rem_y_nx = CNT_W'(q_y ? (rem_y_sh - den_c) : rem_y_sh);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_end_c) state_d = enough_c ? S_DIVIDE : S_DONE;
      S_DIVIDE: if (div_step == DC_LAST) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Pixel-side scan position and per-frame accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      blank_q   <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      acc_cnt   <= '0;
      acc_sx    <= '0;
      acc_sy    <= '0;
      acc_min_x <= '1;
      acc_max_x <= '0;
      acc_min_y <= '1;
      acc_max_y <= '0;
    end else if (en_i) begin
      vs_q    <= vs_ni;
      blank_q <= blank_ni;
      if (frame_end_c) begin
        x_cnt     <= '0;
        y_cnt     <= '0;
        acc_cnt   <= '0;
        acc_sx    <= '0;
        acc_sy    <= '0;
        acc_min_x <= '1;
        acc_max_x <= '0;
        acc_min_y <= '1;
        acc_max_y <= '0;
      end else begin
        if (line_end_c) begin
          x_cnt <= '0;
          if (y_cnt != Y_LIM) y_cnt <= y_cnt + Y_ONE;
        end else if (blank_ni && (x_cnt != X_LIM)) begin
          x_cnt <= x_cnt + X_ONE;
        end
        if (obj_c) begin
          acc_cnt <= acc_cnt + CNT_ONE;
          acc_sx  <= acc_sx + SX_W'(px_x_c);
          acc_sy  <= acc_sy + SY_W'(px_y_c);
          if (px_x_c < acc_min_x) acc_min_x <= px_x_c;
          if (px_x_c > acc_max_x) acc_max_x <= px_x_c;
          if (px_y_c < acc_min_y) acc_min_y <= px_y_c;
          if (px_y_c > acc_max_y) acc_max_y <= px_y_c;
        end
      end
    end
  end

  // Snapshot and divider; the quotient shifts into the dividend registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_cnt   <= '0;
      sh_min_x <= '1;
      sh_max_x <= '0;
      sh_min_y <= '1;
      sh_max_y <= '0;
      sh_ok    <= 1'b0;
      div_x    <= '0;
      div_y    <= '0;
      rem_x    <= '0;
      rem_y    <= '0;
      div_step <= '0;
    end else if (take_c) begin
      sh_cnt   <= acc_cnt;
      sh_min_x <= acc_min_x;
      sh_max_x <= acc_max_x;
      sh_min_y <= acc_min_y;
      sh_max_y <= acc_max_y;
      sh_ok    <= enough_c;
      div_x    <= DIV_W'(acc_sx);
      div_y    <= DIV_W'(acc_sy);
      rem_x    <= '0;
      rem_y    <= '0;
      div_step <= '0;
    end else if (state_q == S_DIVIDE) begin
      div_x    <= {div_x[DIV_W-2:0], q_x};
      div_y    <= {div_y[DIV_W-2:0], q_y};
      rem_x    <= rem_x_nx;
      rem_y    <= rem_y_nx;
      div_step <= div_step + DC_ONE;
    end
  end

  // Result registers, updated only from DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid_o <= 1'b0;
      obj_found_o   <= 1'b0;
      pixel_count_o <= '0;
      centroid_x_o  <= '0;
      centroid_y_o  <= '0;
      min_x_o       <= '0;
      max_x_o       <= '0;
      min_y_o       <= '0;
      max_y_o       <= '0;
      overrun_o     <= 1'b0;
    end else begin
      frame_valid_o <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        obj_found_o   <= sh_ok;
        pixel_count_o <= sh_cnt;
        centroid_x_o  <= sh_ok ? div_x[X_W-1:0] : '0;
        centroid_y_o  <= sh_ok ? div_y[Y_W-1:0] : '0;
        min_x_o       <= sh_min_x;
        max_x_o       <= sh_max_x;
        min_y_o       <= sh_min_y;
        max_y_o       <= sh_max_y;
      end
      if (frame_end_c && (state_q != S_IDLE)) overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mask_centroid_tracker.sv
// Bench for mask_centroid_tracker: fixed vectors, random frames against an
// image-level reference, reset-during-divide and overrun sequences.
module tb_mask_centroid_tracker;

  localparam int unsigned LW = 8, LH = 6, PD = 8, MINP = 2;
  localparam int unsigned XW = 3, YW = 3, CW = 6;
  localparam int LAT_MAX = CW + XW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_i = 1'b0, vs_ni = 1'b0, hs_ni = 1'b1, blank_ni = 1'b0;
  logic [PD-1:0] input_R = '0, input_G = '0, input_B = '0;
  logic frame_valid_o, obj_found_o, overrun_o;
  logic [CW-1:0] pixel_count_o;
  logic [XW-1:0] centroid_x_o, min_x_o, max_x_o;
  logic [YW-1:0] centroid_y_o, min_y_o, max_y_o;

  mask_centroid_tracker #(
    .LINE_WIDTH(LW), .LINE_HEIGHT(LH), .PIXEL_DEPTH(PD), .MIN_PIXELS(MINP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .vs_ni(vs_ni), .hs_ni(hs_ni),
    .blank_ni(blank_ni), .input_R(input_R), .input_G(input_G), .input_B(input_B),
    .frame_valid_o(frame_valid_o), .obj_found_o(obj_found_o),
    .pixel_count_o(pixel_count_o), .centroid_x_o(centroid_x_o),
    .centroid_y_o(centroid_y_o), .min_x_o(min_x_o), .max_x_o(max_x_o),
    .min_y_o(min_y_o), .max_y_o(max_y_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt; int cx; int cy; int minx; int maxx; int miny; int maxy; int found;
  } res_t;

  typedef struct {
    int n;
    logic [3:0][7:0] pix;   // each byte is {y, x}
    bit all_white;
    bit toggle;
    res_t exp;
  } vec_t;

  int  n_cmp = 0, n_err = 0;
  int  strobes = 0;
  bit  img [0:9][0:5];
  vec_t vecs [5];

  always @(negedge clk) if (frame_valid_o === 1'b1) strobes++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic res_t mk(int cnt, int cx, int cy, int minx, int maxx,
                              int miny, int maxy, int found);
    res_t r;
    r.cnt = cnt; r.cx = cx; r.cy = cy; r.minx = minx; r.maxx = maxx;
    r.miny = miny; r.maxy = maxy; r.found = found;
    return r;
  endfunction

  // Reference: statistics of the visible part of the image
  function automatic res_t model();
    res_t r;
    int sx = 0, sy = 0;
    r = mk(0, 0, 0, (1 << XW) - 1, 0, (1 << YW) - 1, 0, 0);
    for (int y = 0; y < LH; y++)
      for (int x = 0; x < LW; x++)
        if (img[x][y]) begin
          r.cnt++; sx += x; sy += y;
          if (x < r.minx) r.minx = x;
          if (x > r.maxx) r.maxx = x;
          if (y < r.miny) r.miny = y;
          if (y > r.maxy) r.maxy = y;
        end
    r.found = (r.cnt >= MINP && r.cnt > 0) ? 1 : 0;
    if (r.found != 0) begin
      r.cx = sx / r.cnt;
      r.cy = sy / r.cnt;
    end
    return r;
  endfunction

  task automatic clear_img();
    for (int x = 0; x < 10; x++)
      for (int y = 0; y < 6; y++) img[x][y] = 1'b0;
  endtask

  // One enabled sample; with toggle, a disabled cycle of junk precedes it
  task automatic drive(input bit vs, input bit blank, input bit white, input bit toggle);
    if (toggle) begin
      en_i = 1'b0; vs_ni = 1'($urandom); hs_ni = 1'($urandom);
      blank_ni = 1'($urandom);
      input_R = 8'hFF; input_G = 8'hFF; input_B = 8'hFF;
      @(posedge clk); #1;
    end
    en_i = 1'b1; vs_ni = vs; hs_ni = blank; blank_ni = blank;
    if (white) begin
      input_R = 8'hFF; input_G = 8'hFF; input_B = 8'hFF;
    end else begin
      input_R = 8'($urandom); input_G = 8'($urandom);
      input_B = 8'($urandom_range(0, 254));
    end
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int lw, input bit toggle);
    repeat (2) drive(1'b1, 1'b0, 1'($urandom), toggle);
    for (int y = 0; y < LH; y++) begin
      for (int x = 0; x < lw; x++) drive(1'b1, 1'b1, img[x][y], toggle);
      repeat (3) drive(1'b1, 1'b0, 1'($urandom), toggle);
    end
    drive(1'b0, 1'b0, 1'($urandom), toggle);
  endtask

  task automatic wait_result(output bit got, output int lat);
    got = 1'b0; lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (frame_valid_o === 1'b1) got = 1'b1;
    end
  endtask

  task automatic cmp_res(input string tag, input res_t e);
    check({tag, " count"}, int'(pixel_count_o), e.cnt);
    check({tag, " found"}, int'(obj_found_o), e.found);
    check({tag, " cx"},    int'(centroid_x_o), e.cx);
    check({tag, " cy"},    int'(centroid_y_o), e.cy);
    check({tag, " min_x"}, int'(min_x_o), e.minx);
    check({tag, " max_x"}, int'(max_x_o), e.maxx);
    check({tag, " min_y"}, int'(min_y_o), e.miny);
    check({tag, " max_y"}, int'(max_y_o), e.maxy);
  endtask

  task automatic run_one(input string tag, input int lw, input bit toggle, input res_t e);
    int s0, lat;
    bit got;
    s0 = strobes;
    run_frame(lw, toggle);
    wait_result(got, lat);
    check({tag, " strobe seen"}, int'(got), 1);
    n_cmp++;
    if (lat > LAT_MAX) begin
      n_err++;
      $display("FAIL %s latency: got %0d clks, limit %0d", tag, lat, LAT_MAX);
    end
    repeat (6) @(negedge clk);
    check({tag, " strobe count"}, strobes - s0, 1);
    cmp_res(tag, e);
  endtask

  task automatic load_vec(input vec_t v);
    clear_img();
    if (v.all_white) begin
      for (int x = 0; x < LW; x++)
        for (int y = 0; y < LH; y++) img[x][y] = 1'b1;
    end else begin
      for (int k = 0; k < v.n; k++) img[int'(v.pix[k][3:0])][int'(v.pix[k][7:4])] = 1'b1;
    end
  endtask

  initial begin
    res_t e;
    int s0, lw, d;
    bit tg;

    vecs[0] = '{n: 3, pix: 32'h0033_1412, all_white: 1'b0, toggle: 1'b0, exp: mk(3, 3, 1, 2, 4, 1, 3, 1)};
    vecs[1] = '{n: 1, pix: 32'h0000_0045, all_white: 1'b0, toggle: 1'b0, exp: mk(1, 0, 0, 5, 5, 4, 4, 0)};
    vecs[2] = '{n: 0, pix: 32'h0,         all_white: 1'b1, toggle: 1'b0, exp: mk(48, 3, 2, 0, 7, 0, 5, 1)};
    vecs[3] = '{n: 3, pix: 32'h0033_1412, all_white: 1'b0, toggle: 1'b1, exp: mk(3, 3, 1, 2, 4, 1, 3, 1)};
    vecs[4] = '{n: 0, pix: 32'h0,         all_white: 1'b0, toggle: 1'b0, exp: mk(0, 0, 0, 7, 0, 7, 0, 0)};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset valid", int'(frame_valid_o), 0);
    check("reset overrun", int'(overrun_o), 0);
    cmp_res("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      load_vec(vecs[i]);
      run_one($sformatf("vec%0d", i), LW, vecs[i].toggle, vecs[i].exp);
    end

    for (int r = 0; r < 10; r++) begin
      lw = ($urandom_range(0, 1) != 0) ? 10 : 8;
      tg = 1'($urandom);
      d  = $urandom_range(0, 3);
      clear_img();
      for (int x = 0; x < lw; x++)
        for (int y = 0; y < LH; y++)
          img[x][y] = ($urandom_range(0, 3) < d);
      e = model();
      run_one($sformatf("rand%0d", r), lw, tg, e);
    end

    // Reset pulsed while the divider is busy
    load_vec(vecs[0]);
    s0 = strobes;
    run_frame(LW, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst-mid valid", int'(frame_valid_o), 0);
    cmp_res("rst-mid", mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst-mid no strobe", strobes - s0, 0);
    run_one("after-rst", LW, 1'b0, vecs[0].exp);

    // Wide lines with out-of-range white, then a second vsync during the divide
    load_vec(vecs[0]);
    for (int y = 0; y < LH; y++) begin
      img[8][y] = 1'b1;
      img[9][y] = 1'b1;
    end
    s0 = strobes;
    run_frame(10, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("overrun before", int'(overrun_o), 0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    check("overrun set", int'(overrun_o), 1);
    check("overrun strobes", strobes - s0, 1);
    cmp_res("overrun", vecs[0].exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
